udma_spim_tx_prefetch: RTL and testbench

//  Credit-based prefetcher between the uDMA TX channel (req/gnt + valid/ready)
//  and the SPI master TX clock-domain-crossing FIFO (valid/ready stream).

---
 rtl/udma_spim_tx_prefetch.sv | 142 ++++++++++++++
 tb/tb_udma_spim_tx_prefetch.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/udma_spim_tx_prefetch.sv
// ============================================================================
// Module  : udma_spim_tx_prefetch
// Brief   : Credit-based prefetch buffer between the uDMA TX channel and the
//           SPI master TX CDC FIFO; requests issue only with reserved space.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module udma_spim_tx_prefetch #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clr_i,
    output logic                         req_o,
    input  logic                         gnt_i,
    input  logic                         valid_i,
    input  logic [DATA_WIDTH-1:0]        data_i,
    output logic                         ready_o,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         err_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0]   C_DEPTH_EXT = (CW+1)'(DEPTH);
    localparam logic [PW-1:0] C_LAST_PTR  = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [CW-1:0] level_q, level_d;
    logic [CW-1:0] out_q,   out_d;
    logic [CW-1:0] drop_q,  drop_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          err_q,   err_d;

    logic [CW:0]   w_committed;
    logic          w_grant;
    logic          w_resp;
    logic          w_drop;
    logic          w_take;
    logic          w_orphan;
    logic          w_push;
    logic          w_pop;

    // Credits in use are words buffered plus words already granted.
    assign w_committed = {1'b0, level_q} + {1'b0, out_q};

    assign req_o   = !rst_i && !clr_i && (drop_q == '0) && (w_committed < C_DEPTH_EXT);
    assign ready_o = !rst_i;
    assign valid_o = (level_q != '0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign level_o = level_q;
    assign err_o   = err_q;

    assign w_grant  = req_o && gnt_i;
    assign w_resp   = valid_i && !rst_i;
    assign w_drop   = w_resp && (drop_q != '0);
    assign w_take   = w_resp && (drop_q == '0) && (out_q != '0);
    assign w_orphan = w_resp && (drop_q == '0) && (out_q == '0);
    assign w_push   = w_take && !clr_i;
    assign w_pop    = valid_o && ready_i && !clr_i;

    always_comb begin
        level_d  = level_q;
        out_d    = out_q;
        drop_d   = drop_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = err_q | w_orphan;

        if (w_grant && !w_take) begin
            out_d = out_q + CW'(1);
        end else if (!w_grant && w_take) begin
            out_d = out_q - CW'(1);
        end

        if (w_drop) begin
            drop_d = drop_q - CW'(1);
        end

        if (w_push && !w_pop) begin
            level_d = level_q + CW'(1);
        end else if (!w_push && w_pop) begin
            level_d = level_q - CW'(1);
        end

        if (w_push) begin
            wr_ptr_d = (wr_ptr_q == C_LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        end
        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == C_LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
        end

        // Every still-outstanding grant becomes a response to be discarded;
        // a response taken this cycle has already been retired from out_q.
        if (clr_i) begin
            level_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            out_d    = '0;
            drop_d   = drop_d + (w_take ? (out_q - CW'(1)) : out_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_q  <= '0;
            out_q    <= '0;
            drop_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            level_q  <= level_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

`ifndef SYNTHESIS
    a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_push && !w_pop && (level_q == CW'(DEPTH))));
`endif

endmodule

`default_nettype wire

// File: tb/tb_udma_spim_tx_prefetch.sv
// ============================================================================
// Module  : tb_udma_spim_tx_prefetch
// Brief   : Directed and randomized checks of the TX prefetcher against a
//           queue-based credit model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_udma_spim_tx_prefetch;

    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst_i, clr_i, gnt_i, valid_i, ready_i;
    logic [DW-1:0] data_i;
    logic          req_o, ready_o, valid_o, err_o;
    logic [DW-1:0] data_o;
    logic [2:0]    level_o;

    udma_spim_tx_prefetch #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .clr_i   (clr_i),
        .req_o   (req_o),
        .gnt_i   (gnt_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .level_o (level_o),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    // Reference model: buffered words, owed responses split into kept/dropped.
    logic [DW-1:0] q[$];
    int  outst = 0;
    int  drop  = 0;
    bit  err   = 0;
    bit  last_gnt = 0;
    int  grants = 0;
    bit  en_chk = 0;
    int  total = 0;
    int  bad   = 0;
    logic [DW-1:0] next_word = 32'hA0;

    task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cycle();
        bit exp_req, take, pop;
        @(negedge clk);
        exp_req = !rst_i && !clr_i && drop == 0 && (q.size() + outst) < DEPTH;
        if (en_chk) begin
            check_eq("req_o",   {31'd0, req_o},   {31'd0, exp_req});
            check_eq("ready_o", {31'd0, ready_o}, {31'd0, !rst_i});
            check_eq("valid_o", {31'd0, valid_o}, {31'd0, q.size() != 0});
            check_eq("data_o",  data_o, (q.size() != 0) ? q[0] : '0);
            check_eq("level_o", {29'd0, level_o}, q.size());
            check_eq("err_o",   {31'd0, err_o},   {31'd0, err});
        end
        last_gnt = exp_req && gnt_i;
        if (last_gnt) grants++;
        if (rst_i) begin
            q.delete();
            outst = 0;
            drop  = 0;
            err   = 0;
            last_gnt = 0;
        end else begin
            take = 0;
            pop  = q.size() != 0 && ready_i && !clr_i;
            if (valid_i) begin
                if (drop > 0) drop--;
                else if (outst > 0) begin outst--; take = 1; end
                else err = 1;
            end
            if (last_gnt) outst++;
            if (pop) void'(q.pop_front());
            if (take && !clr_i) q.push_back(data_i);
            if (clr_i) begin
                q.delete();
                drop += outst;
                outst = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit c, input bit g, input bit v, input bit r, input logic [DW-1:0] d);
        clr_i = c; gnt_i = g; valid_i = v; ready_i = r; data_i = d;
        cycle();
    endtask

    // uDMA answers every grant exactly one cycle later.
    task automatic follow(input bit g, input bit r);
        clr_i = 1'b0; gnt_i = g; ready_i = r; valid_i = last_gnt;
        if (last_gnt) begin
            data_i = next_word;
            next_word++;
        end
        cycle();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        drive(0, 0, 0, 0, '0);
        drive(0, 0, 0, 0, '0);
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; clr_i = 0; gnt_i = 0; valid_i = 0; ready_i = 0; data_i = '0;
        cycle();
        en_chk = 1;
        cycle();
        check_eq("rst_level", {29'd0, level_o}, 0);
        check_eq("rst_valid", {31'd0, valid_o}, 0);
        rst_i = 1'b0;

        // Fill with no drain: exactly DEPTH grants.
        grants = 0;
        repeat (10) follow(1, 0);
        check_eq("t1_grants", grants, 4);
        check_eq("t1_level",  {29'd0, level_o}, 4);
        check_eq("t1_data",   data_o, 32'hA0);
        check_eq("t1_req",    {31'd0, req_o}, 0);

        // One pop frees one credit.
        follow(1, 1);
        check_eq("t2_level", {29'd0, level_o}, 3);
        check_eq("t2_req",   {31'd0, req_o}, 1);
        check_eq("t2_head",  data_o, 32'hA1);
        repeat (4) follow(1, 0);

        // Continuous drain while refilling.
        repeat (16) follow(1, 1);
        check_eq("t3_err", {31'd0, err_o}, 0);
        repeat (6) follow(0, 1);

        // Flush with two responses in flight.
        do_reset();
        drive(0, 1, 0, 0, '0);
        drive(0, 1, 1, 0, 32'h11);
        drive(0, 1, 0, 0, '0);
        check_eq("t4_pre_level", {29'd0, level_o}, 1);
        drive(1, 1, 0, 0, '0);
        check_eq("t4_valid", {31'd0, valid_o}, 0);
        check_eq("t4_level", {29'd0, level_o}, 0);
        check_eq("t4_req0",  {31'd0, req_o}, 0);
        drive(0, 1, 1, 0, 32'h22);
        check_eq("t4_req1",  {31'd0, req_o}, 0);
        drive(0, 0, 1, 0, 32'h33);
        check_eq("t4_req2",  {31'd0, req_o}, 1);
        check_eq("t4_level2", {29'd0, level_o}, 0);

        // Response without credit.
        drive(0, 0, 1, 0, 32'hDEAD);
        check_eq("t5_err",   {31'd0, err_o}, 1);
        check_eq("t5_level", {29'd0, level_o}, 0);
        repeat (3) drive(0, 0, 0, 1, '0);
        check_eq("t5_sticky", {31'd0, err_o}, 1);

        // Reset with level 3 and one outstanding.
        do_reset();
        last_gnt = 0;
        repeat (4) follow(1, 0);
        check_eq("t6_level", {29'd0, level_o}, 3);
        rst_i = 1'b1;
        drive(0, 0, 0, 0, '0);
        check_eq("t6_level_r", {29'd0, level_o}, 0);
        check_eq("t6_valid_r", {31'd0, valid_o}, 0);
        check_eq("t6_data_r",  data_o, '0);
        check_eq("t6_req_r",   {31'd0, req_o}, 0);
        check_eq("t6_ready_r", {31'd0, ready_o}, 0);
        check_eq("t6_err_r",   {31'd0, err_o}, 0);
        rst_i = 1'b0;
        drive(0, 0, 0, 0, '0);

        // Randomized traffic; responses only while owed.
        for (int i = 0; i < 3000; i++) begin
            rst_i   = ($urandom % 500) == 0;
            clr_i   = !rst_i && (($urandom % 40) == 0);
            gnt_i   = $urandom % 2;
            ready_i = ($urandom % 4) != 0;
            valid_i = (outst + drop) > 0 && ($urandom % 2);
            data_i  = $urandom;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
